tick_counter: RTL

- Parametrised synchronous successor to the board-level ripple counter.
- Built-in prescaler divides `clk` down to a one-cycle step strobe. The strobe advances a WIDTH-bit up/down counter with synchronous load.
- There is no derived or gated clock: everything runs on `clk`. This replaces the flip-flop divider plus ripple chain used for LED demos.
- Sits between the board clock and LED/7-seg display logic. `tick` and `tc` are exported for cascading.

---
 rtl/counter_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 49 ++++
 rtl/tick_counter.sv | 96 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the tick_counter block.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  localparam int unsigned DEFAULT_DIV = 32'd5000000;

  // Bits needed to hold 0..v-1, never less than one so a DIV of 1 still has a register.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) begin
        r = 32'(i + 1);
      end else begin
        r = r;
      end
    end
    if (r == 32'd0) begin
      return 32'd1;
    end else begin
      return r;
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV phase counter producing a combinational step strobe.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int unsigned    DIV_W = clog2_min1(DIV);
  localparam logic [DIV_W-1:0] LAST  = DIV_W'(DIV - 32'd1);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(32'd1);
  localparam logic [DIV_W-1:0] ZERO  = DIV_W'(32'd0);

  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;

  assign step = en && (presc_q == LAST);

  // Next phase: clear wins, then advance/wrap while enabled, otherwise hold.
  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = ZERO;
    end else if (en) begin
      if (presc_q == LAST) begin
        presc_d = ZERO;
      end else begin
        presc_d = presc_q + ONE;
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= ZERO;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/tick_counter.sv
// Prescaled WIDTH-bit up/down counter with load, tick and terminal-count pulses.
// Define TICK_COUNTER_SAT_EN to make the count saturate at its bounds instead of wrapping.
module tick_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd4,
  parameter int unsigned DIV   = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(32'd1);

  logic             step_s;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tick_q;
  logic             tick_d;
  logic             tc_q;
  logic             tc_d;

  tick_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .step (step_s)
  );

  // Load beats a coincident step; at a bound the step either wraps or pins, flagging tc.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (step_s) begin
      tick_d = 1'b1;
      if (up == CNT_UP) begin
        if (count_q == CNT_MAX) begin
          tc_d = 1'b1;
`ifdef TICK_COUNTER_SAT_EN
          count_d = count_q;
`else
          count_d = CNT_ZERO;
`endif
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else begin
        if (count_q == CNT_ZERO) begin
          tc_d = 1'b1;
`ifdef TICK_COUNTER_SAT_EN
          count_d = count_q;
`else
          count_d = CNT_MAX;
`endif
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= CNT_ZERO;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign tc    = tc_q;

endmodule
